// File: rtl/result_drain_if.sv
// result_drain_if: output stream of the result drain stage.
//   master side (drain)    : drives out_valid, out_data, out_idx, out_last
//   slave side  (consumer) : drives out_ready
// A beat transfers on a clock edge where out_valid && out_ready.
interface result_drain_if #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int IDX_W = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/result_drain.sv
// result_drain: snapshots the mesh accumulator vector on a capture pulse,
// requantizes every accumulator (rounding arithmetic right shift, optional
// ReLU, signed saturation to DW bits) and streams the frame out as
// ROWS/LANES beats of LANES elements over a valid/ready interface.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   capture      : single-cycle snapshot request
//   result_flat  : ROWS signed ACC_W accumulators, element i at [i*ACC_W +: ACC_W]
//   shift        : right-shift amount, sampled at capture
//   relu_en      : clamp negatives to 0, sampled at capture
//   busy         : a frame is held and not yet fully drained
//   sat_count    : saturated lanes in the current/last frame (sticks at 0xFFFF)
//   out_if       : output stream (out_valid/out_ready/out_data/out_idx/out_last)
module result_drain #(
  parameter int ROWS    = 128,
  parameter int ACC_W   = 16,
  parameter int DW      = 8,
  parameter int LANES   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic [ROWS*ACC_W-1:0]   result_flat,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    relu_en,
  output logic                    busy,
  output logic [15:0]             sat_count,
  result_drain_if.master          out_if
);

  localparam int BEATS   = ROWS / LANES;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W   = $clog2(LANES + 1);
  localparam int BEAT_W  = LANES * ACC_W;

  // Saturation bounds expressed in the widened (ACC_W+1) arithmetic domain.
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (DW-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2 ** (DW-1)));

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [ROWS*ACC_W-1:0]  snap_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic                   relu_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            sat_q, sat_d;

  logic                   out_valid;
  logic                   handshake;
  logic                   last_beat;
  logic                   cap_accept;
  logic [BEAT_W-1:0]      beat_acc;
  logic [LANES*DW-1:0]    beat_data;
  logic [LANES-1:0]       lane_sat;
  logic [CNT_W-1:0]       beat_sat_cnt;
  logic [16:0]            sat_sum;
  logic signed [ACC_W:0]  rnd;

  assign out_valid = (state_q == STREAM);
  assign handshake = out_valid && out_if.out_ready;
  assign last_beat = (idx_q == IDX_W'(BEATS - 1));

  // A new frame may start while idle, or exactly on the final handshake of
  // the current frame so back-to-back frames stream without a bubble.
  assign cap_accept = capture && ((state_q == IDLE) || (handshake && last_beat));

  // Beat selection is combinational from the snapshot, so out_data only
  // changes when out_idx or the snapshot changes, i.e. never during a stall.
  assign beat_acc = snap_q[idx_q * BEAT_W +: BEAT_W];

  // Half-LSB rounding constant, shared by every lane.
  assign rnd = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - SHIFT_W'(1)));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] relu_v;
    logic                  hi;
    logic                  lo;

    // One extra bit so a positive full-scale value plus the rounding
    // constant cannot wrap negative.
    assign acc_ext = {beat_acc[gi*ACC_W + ACC_W - 1], beat_acc[gi*ACC_W +: ACC_W]};
    assign sum     = acc_ext + rnd;
    assign shifted = sum >>> shift_q;
    assign relu_v  = (relu_q && shifted[ACC_W]) ? '0 : shifted;
    assign hi      = (relu_v > SAT_MAX);
    assign lo      = (relu_v < SAT_MIN);

    // ReLU zeroing happens before this point, so it never counts as saturation.
    assign lane_sat[gi] = hi || lo;
    assign beat_data[gi*DW +: DW] = hi ? SAT_MAX[DW-1:0] :
                                    lo ? SAT_MIN[DW-1:0] :
                                         relu_v[DW-1:0];
  end

  always_comb begin
    beat_sat_cnt = '0;
    for (int j = 0; j < LANES; j++) begin
      beat_sat_cnt = beat_sat_cnt + CNT_W'(lane_sat[j]);
    end
  end

  assign sat_sum = {1'b0, sat_q} + 17'(beat_sat_cnt);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (cap_accept) begin
          state_d = STREAM;
          idx_d   = '0;
          sat_d   = '0;
        end
      end
      STREAM: begin
        if (cap_accept) begin
          // Last beat handed over and a new frame starts in the same cycle.
          idx_d = '0;
          sat_d = '0;
        end else if (handshake) begin
          idx_d = last_beat ? '0 : idx_q + IDX_W'(1);
          sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sat_q   <= '0;
      snap_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      if (cap_accept) begin
        snap_q  <= result_flat;
        shift_q <= shift;
        relu_q  <= relu_en;
      end
    end
  end

  // All outputs derive from state registers, so an asynchronous reset
  // clears them without waiting for a clock.
  assign busy             = out_valid;
  assign sat_count        = sat_q;
  assign out_if.out_valid = out_valid;
  assign out_if.out_data  = out_valid ? beat_data : '0;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = out_valid && last_beat;

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: self-checking bench for result_drain. A table of uniform
// frames with known per-lane results, hand sequences for rounding, stalls,
// capture collisions and mid-frame reset, and random frames checked against
// an integer-arithmetic reference model.
module tb_result_drain;

  localparam int ROWS    = 128;
  localparam int ACC_W   = 16;
  localparam int DW      = 8;
  localparam int LANES   = 8;
  localparam int SHIFT_W = 4;
  localparam int BEATS   = ROWS / LANES;
  localparam int IDX_W   = 4;
  localparam int FW      = ROWS * ACC_W;

  logic                clk;
  logic                rst;
  logic                capture;
  logic [FW-1:0]       result_flat;
  logic [SHIFT_W-1:0]  shift;
  logic                relu_en;
  logic                busy;
  logic [15:0]         sat_count;

  result_drain_if #(.LANES(LANES), .DW(DW), .IDX_W(IDX_W)) dif ();

  result_drain #(
    .ROWS(ROWS), .ACC_W(ACC_W), .DW(DW), .LANES(LANES), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .result_flat (result_flat),
    .shift       (shift),
    .relu_en     (relu_en),
    .busy        (busy),
    .sat_count   (sat_count),
    .out_if      (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [LANES*DW-1:0] exp_beat [BEATS];
  int                  exp_sat;

  typedef struct {
    logic [15:0] fill;
    int          sh;
    bit          relu;
    logic [7:0]  lane;
    int          sat;
  } vec_t;

  vec_t tbl [10];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference requantization using floor division on plain integers.
  function automatic int req_elem(int a, int sh, bit relu, output bit sat);
    int d, v, q;
    d = 1 << sh;
    v = a + ((sh > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    sat = 1'b0;
    if (q > (2 ** (DW-1)) - 1) begin
      q = (2 ** (DW-1)) - 1;
      sat = 1'b1;
    end else if (q < -(2 ** (DW-1))) begin
      q = -(2 ** (DW-1));
      sat = 1'b1;
    end
    return q;
  endfunction

  task automatic build_model(input logic [FW-1:0] flat, input int sh, input bit relu);
    int a, q;
    bit s;
    logic [31:0] qv;
    exp_sat = 0;
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < LANES; j++) begin
        a  = int'($signed(flat[(b*LANES + j)*ACC_W +: ACC_W]));
        q  = req_elem(a, sh, relu, s);
        qv = q;
        exp_beat[b][j*DW +: DW] = qv[DW-1:0];
        exp_sat += int'(s);
      end
    end
  endtask

  function automatic logic [FW-1:0] rand_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < ROWS; i++) f[i*ACC_W +: ACC_W] = ACC_W'($urandom);
    return f;
  endfunction

  // Presents a capture for one edge and returns at posedge+1 with the model built.
  task automatic capture_frame(input logic [FW-1:0] flat, input int sh, input bit relu);
    @(negedge clk);
    dif.out_ready = 1'b0;
    result_flat   = flat;
    shift         = SHIFT_W'(sh);
    relu_en       = relu;
    capture       = 1'b1;
    build_model(flat, sh, relu);
    @(posedge clk);
    #1;
    capture     = 1'b0;
    result_flat = rand_flat();
  endtask

  // Drains the frame currently streaming, checking every cycle against the
  // model. mode 0: always ready, 1: random ready, 2: 5-cycle stall at beat 3.
  // cap_idx >= 0 injects a capture (inj_*) while that beat is presented;
  // chain means that capture is expected to start the next frame.
  task automatic drain_check(input int mode, input int cap_idx, input bit chain,
                             input logic [FW-1:0] inj_flat, input int inj_sh,
                             input bit inj_relu);
    int exp_idx = 0;
    int hs = 0;
    int cyc = 0;
    int stall = 0;
    bit rdy;
    bit injected = 1'b0;
    while (hs < BEATS && cyc < 400) begin
      @(negedge clk);
      capture = 1'b0;
      check("out_valid", 64'(dif.out_valid), 64'(1));
      check("busy", 64'(busy), 64'(1));
      check("out_idx", 64'(dif.out_idx), 64'(exp_idx));
      check("out_data", 64'(dif.out_data), 64'(exp_beat[exp_idx]));
      check("out_last", 64'(dif.out_last), 64'(exp_idx == BEATS - 1));
      if (cyc == 0) check("sat_cleared", 64'(sat_count), 64'(0));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (exp_idx == 3 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      if (exp_idx == cap_idx && !injected) begin
        capture     = 1'b1;
        result_flat = inj_flat;
        shift       = SHIFT_W'(inj_sh);
        relu_en     = inj_relu;
        injected    = 1'b1;
      end else begin
        result_flat = rand_flat();
      end
      dif.out_ready = rdy;
      if (rdy) begin
        hs++;
        exp_idx++;
      end
      cyc++;
    end
    if (hs < BEATS) check("drain_timeout", 64'(hs), 64'(BEATS));
    if (mode == 2) check("stall_cycles", 64'(stall), 64'(5));
    if (!chain) begin
      @(negedge clk);
      capture       = 1'b0;
      dif.out_ready = 1'b0;
      check("idle_valid", 64'(dif.out_valid), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_last", 64'(dif.out_last), 64'(0));
      check("idle_data", 64'(dif.out_data), 64'(0));
      check("frame_sat", 64'(sat_count), 64'(exp_sat));
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, 64'(dif.out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_idx"}, 64'(dif.out_idx), 64'(0));
    check({tag, "_last"}, 64'(dif.out_last), 64'(0));
    check({tag, "_data"}, 64'(dif.out_data), 64'(0));
    check({tag, "_sat"}, 64'(sat_count), 64'(0));
  endtask

  initial begin
    logic [FW-1:0] f1;
    logic [FW-1:0] f2;
    int            sh2;
    bit            relu2;
    int            cyc;
    logic [15:0]   v;

    tbl[0] = '{16'h0100, 1,  1'b0, 8'h7F, 128};
    tbl[1] = '{16'hFED4, 0,  1'b1, 8'h00, 0};
    tbl[2] = '{16'hFED4, 0,  1'b0, 8'h80, 128};
    tbl[3] = '{16'd100,  0,  1'b0, 8'd100, 0};
    tbl[4] = '{16'h7FFF, 15, 1'b0, 8'h01, 0};
    tbl[5] = '{16'h8000, 15, 1'b0, 8'hFF, 0};
    tbl[6] = '{16'd255,  1,  1'b0, 8'h7F, 128};
    tbl[7] = '{16'hFEFF, 1,  1'b0, 8'h80, 0};
    tbl[8] = '{16'd254,  1,  1'b0, 8'h7F, 0};
    tbl[9] = '{16'h8000, 0,  1'b1, 8'h00, 0};

    rst           = 1'b1;
    capture       = 1'b0;
    result_flat   = '0;
    shift         = '0;
    relu_en       = 1'b0;
    dif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Uniform frames with known per-lane result and saturation total.
    for (int t = 0; t < 10; t++) begin
      capture_frame({ROWS{tbl[t].fill}}, tbl[t].sh, tbl[t].relu);
      check("tbl_beat0", 64'(dif.out_data), 64'({LANES{tbl[t].lane}}));
      drain_check(0, -1, 1'b0, '0, 0, 1'b0);
      check("tbl_sat", 64'(sat_count), 64'(tbl[t].sat));
      $display("[TB] table %0d: fill=0x%04h shift=%0d relu=%0d sat_count=%0d",
               t, tbl[t].fill, tbl[t].sh, tbl[t].relu, sat_count);
    end

    // Rounding of mixed-sign values, then pass-through with shift 0.
    f1 = '0;
    v = 16'd5;      f1[0*ACC_W +: ACC_W] = v;
    v = -16'sd5;    f1[1*ACC_W +: ACC_W] = v;
    v = -16'sd3;    f1[2*ACC_W +: ACC_W] = v;
    v = 16'd7;      f1[3*ACC_W +: ACC_W] = v;
    capture_frame(f1, 1, 1'b0);
    check("round_sh1", 64'(dif.out_data[31:0]), 64'(32'h04FFFE03));
    drain_check(0, -1, 1'b0, '0, 0, 1'b0);
    capture_frame(f1, 0, 1'b0);
    check("round_sh0", 64'(dif.out_data[31:0]), 64'(32'h07FDFB05));
    drain_check(0, -1, 1'b0, '0, 0, 1'b0);
    $display("[TB] rounding frames done");

    // Backpressure: 5-cycle stall at beat 3, source mutated every cycle.
    capture_frame(rand_flat(), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain_check(2, -1, 1'b0, '0, 0, 1'b0);
    $display("[TB] backpressure frame sat_count=%0d", sat_count);

    // Capture at beat 7 is ignored; the old frame completes unchanged.
    capture_frame(rand_flat(), 4, 1'b0);
    drain_check(0, 7, 1'b0, rand_flat(), 9, 1'b1);
    $display("[TB] ignored-capture frame sat_count=%0d", sat_count);

    // Capture on the final handshake starts the next frame with no bubble.
    capture_frame(rand_flat(), 2, 1'b0);
    f2    = rand_flat();
    sh2   = 6;
    relu2 = 1'b1;
    drain_check(0, BEATS - 1, 1'b1, f2, sh2, relu2);
    build_model(f2, sh2, relu2);
    drain_check(0, -1, 1'b0, '0, 0, 1'b0);
    $display("[TB] back-to-back frames done sat_count=%0d", sat_count);

    // Asynchronous reset in mid-frame, away from any clock edge.
    capture_frame(rand_flat(), 1, 1'b0);
    dif.out_ready = 1'b1;
    cyc = 0;
    while (dif.out_idx != IDX_W'(9) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx9", 64'(dif.out_idx), 64'(9));
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    dif.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("post_rst");
    capture_frame(rand_flat(), 3, 1'b1);
    drain_check(0, -1, 1'b0, '0, 0, 1'b0);
    $display("[TB] reset-recovery frame sat_count=%0d", sat_count);

    // Random frames with random consumer backpressure.
    for (int r = 0; r < 5; r++) begin
      capture_frame(rand_flat(), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      drain_check(1, -1, 1'b0, '0, 0, 1'b0);
      $display("[TB] random frame %0d sat_count=%0d", r, sat_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the 2-D mesh array. On a capture pulse it snapshots the mesh's flat accumulator vector (ROWS × ACC_W). It then requantizes each accumulator to DW bits using a rounding arithmetic right shift, an optional ReLU and signed saturation. The results leave as a valid/ready stream of LANES elements per beat, so the consumer (output buffer or next-layer x-vector loader) is decoupled from the mesh.

## Interface

- Parameters
- ROWS, 128, number of accumulators in result_flat; must be a multiple of LANES
- ACC_W, 16, accumulator width (signed)
- DW, 8, output element width (signed)
- LANES, 8, elements per output beat
- SHIFT_W, 4, width of the shift control
- Derived: BEATS = ROWS/LANES (16); IDX_W = clog2(BEATS) (4)
- Ports
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- capture  in  1  single-cycle request to snapshot result_flat
- result_flat  in  ROWS*ACC_W  signed accumulators; element i at [i*ACC_W +: ACC_W]
- shift  in  SHIFT_W  right-shift amount, 0..15; sampled at capture
- relu_en  in  1  clamp negatives to 0; sampled at capture
- busy  out  1  frame held and not yet fully drained
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  LANES*DW  lane j at [j*DW +: DW] = element out_idx*LANES+j
- out_idx  out  IDX_W  beat index within frame
- out_last  out  1  high with the beat whose out_idx = BEATS-1
- sat_count  out  16  lanes saturated in the current/last frame

## Operation

- FSM has two states: IDLE and STREAM. Reset puts it in IDLE. All outputs reset to 0 (busy, out_valid, out_idx, out_last, out_data, sat_count); the snapshot register resets to 0.
- Capture is accepted when the state is IDLE, or in STREAM in the same cycle as the handshake of the last beat. On acceptance:
  - latch result_flat, shift and relu_en;
  - set out_idx=0 and clear sat_count;
  - go to STREAM.
- A capture in STREAM on any other cycle is ignored. The snapshot is not modified and no error is flagged.
- In STREAM, out_valid=1 and busy=1.
  - A handshake is out_valid && out_ready. It advances out_idx and adds the number of saturated lanes of that beat to sat_count. sat_count sticks at 0xFFFF.
  - The handshake at out_idx=BEATS-1 returns to IDLE, unless a capture is accepted in that same cycle.
- Per-lane arithmetic, applied to signed value a (ACC_W bits):
  - r = (a + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed in ACC_W+1 bits so the rounding add cannot overflow.
  - If relu_en and r<0, then r=0.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1]. A lane counts as saturated only when clamping occurs here; ReLU zeroing does not count.
- out_data is derived from the snapshot register and out_idx, with at most one register stage. It must be stable while out_valid && !out_ready.

## Timing

- Capture accepted at edge t: out_valid=1, out_idx=0 and beat-0 data are visible after edge t.
- With out_ready held high, one beat per cycle: BEATS cycles per frame and no bubble between back-to-back frames.
- The last handshake at edge t with no capture: out_valid=0 and busy=0 after t. sat_count holds its frame total until the next accepted capture.
- The mesh may change result_flat at any time after the capture edge; the output is unaffected.
- Asserting rst in mid-frame returns all outputs to 0 and the FSM to IDLE immediately, with no clock needed. The partial frame is discarded.

## Test plan

- Saturation: every acc=0x0100, shift=1, relu_en=0, capture, out_ready=1.
  - Expect 16 beats, every lane 127 (0x7F), out_idx 0..15, and out_last only on beat 15.
  - sat_count=128; busy falls the cycle after beat 15.
- Rounding: elements 0..3 = 5, -5, -3, 7 with shift=1.
  - Beat 0 lanes 0..3 = 3, -2, -1, 4.
  - With shift=0 the same inputs pass through unchanged.
- ReLU: acc=-300, shift=0.
  - relu_en=1: all lanes 0, sat_count=0.
  - relu_en=0: all lanes -128 (0x80), sat_count=128.
- Backpressure: drop out_ready for 5 cycles while out_idx=3.
  - out_valid, out_idx=3 and out_data stay stable.
  - Exactly 16 handshakes in total, and the frame content matches the reference model.
  - Changing result_flat in mid-frame does not alter the output.
- Capture collisions:
  - A capture at out_idx=7 is ignored: the frame completes with the old data.
  - A capture during the out_idx=15 handshake: the next cycle shows out_valid=1, out_idx=0 with new data, and sat_count is cleared.
- Reset mid-frame: assert rst asynchronously (off the clock edge) at out_idx=9.
  - All outputs go to 0 before the next edge.
  - After release, a new capture streams from out_idx=0.
